// File: rtl/line_buffer_ctrl.sv
// rtl/line_buffer_ctrl.sv - ping-pong line buffer controller over a two-bank dual-port RAM
// Optional statistics counters are built when LINE_BUFFER_CTRL_STATS_EN is defined.
module line_buffer_ctrl #(
  parameter int LINE_W = 480,
  parameter int DATA_W = 24,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic              line_start,
  input  logic              rd_en,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_active,
  output logic              underrun,
  output logic [ADDR_W-1:0] mem_ada,
  output logic [DATA_W-1:0] mem_dina,
  output logic              mem_cea,
  output logic              mem_wrea,
  output logic [ADDR_W-1:0] mem_adb,
  output logic              mem_ceb,
  input  logic [DATA_W-1:0] mem_doutb
`ifdef LINE_BUFFER_CTRL_STATS_EN
  ,
  output logic [15:0]       underrun_cnt,
  output logic [15:0]       abort_cnt
`endif
);

  localparam int IW = ADDR_W - 1;
  localparam logic [IW-1:0] WR_LAST = IW'(LINE_W - 1);
  localparam logic [IW:0]   RD_LAST = ADDR_W'(LINE_W - 1);
  localparam logic [IW:0]   RD_END  = ADDR_W'(LINE_W);

  typedef enum logic [1:0] {IDLE, BANK, BLANK} rd_mode_t;

  logic [1:0]    full_q, full_d;
  logic [IW:0]   len0_q, len0_d, len1_q, len1_d;
  logic          wr_bank_q, wr_bank_d;
  logic [IW-1:0] wr_idx_q, wr_idx_d;
  logic          rd_bank_q, rd_bank_d;
  logic [IW:0]   rd_idx_q, rd_idx_d;
  rd_mode_t      rd_mode_q, rd_mode_d;
  logic          rd_valid_q, rd_valid_d;
  logic          rd_pix_q, rd_pix_d;
  logic          underrun_q, underrun_d;

  logic          wr_fire, wr_done, rd_acc, new_bank;
  logic [IW:0]   cur_len;

  assign wr_fire = !reset && s_valid && !full_q[wr_bank_q];
  assign wr_done = wr_fire && (s_last || wr_idx_q == WR_LAST);
  assign rd_acc  = !reset && rd_en && !line_start && rd_mode_q != IDLE && rd_idx_q < RD_END;
  assign cur_len = rd_bank_q ? len1_q : len0_q;

  always_comb begin
    full_d     = full_q;
    len0_d     = len0_q;
    len1_d     = len1_q;
    wr_bank_d  = wr_bank_q;
    wr_idx_d   = wr_idx_q;
    rd_bank_d  = rd_bank_q;
    rd_idx_d   = rd_idx_q;
    rd_mode_d  = rd_mode_q;
    rd_valid_d = rd_acc;
    rd_pix_d   = rd_acc && rd_mode_q == BANK && rd_idx_q < cur_len;
    underrun_d = 1'b0;
    new_bank   = rd_bank_q;

    // A line_start during a BANK line aborts it; the next line judges fullness on pre-update flags.
    if (line_start) begin
      if (rd_mode_q == BANK) begin
        full_d[rd_bank_q] = 1'b0;
        new_bank          = !rd_bank_q;
      end
      rd_bank_d = new_bank;
      rd_idx_d  = '0;
      if (full_q[new_bank]) begin
        rd_mode_d = BANK;
      end else begin
        rd_mode_d  = BLANK;
        underrun_d = 1'b1;
      end
    end else if (rd_acc) begin
      rd_idx_d = rd_idx_q + ADDR_W'(1);
      if (rd_idx_q == RD_LAST) begin
        rd_mode_d = IDLE;
        if (rd_mode_q == BANK) begin
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = !rd_bank_q;
        end
      end
    end

    // Completion targets wr_bank, which is never the full bank being released above.
    if (wr_fire) begin
      wr_idx_d = wr_idx_q + IW'(1);
      if (wr_done) begin
        full_d[wr_bank_q] = 1'b1;
        if (wr_bank_q) len1_d = {1'b0, wr_idx_q} + ADDR_W'(1);
        else           len0_d = {1'b0, wr_idx_q} + ADDR_W'(1);
        wr_bank_d = !wr_bank_q;
        wr_idx_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q     <= '0;
      len0_q     <= '0;
      len1_q     <= '0;
      wr_bank_q  <= 1'b0;
      wr_idx_q   <= '0;
      rd_bank_q  <= 1'b0;
      rd_idx_q   <= '0;
      rd_mode_q  <= IDLE;
      rd_valid_q <= 1'b0;
      rd_pix_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      full_q     <= full_d;
      len0_q     <= len0_d;
      len1_q     <= len1_d;
      wr_bank_q  <= wr_bank_d;
      wr_idx_q   <= wr_idx_d;
      rd_bank_q  <= rd_bank_d;
      rd_idx_q   <= rd_idx_d;
      rd_mode_q  <= rd_mode_d;
      rd_valid_q <= rd_valid_d;
      rd_pix_q   <= rd_pix_d;
      underrun_q <= underrun_d;
    end
  end

  assign s_ready   = !reset && !full_q[wr_bank_q];
  assign mem_cea   = wr_fire;
  assign mem_wrea  = wr_fire;
  assign mem_ada   = wr_fire ? {wr_bank_q, wr_idx_q} : '0;
  assign mem_dina  = wr_fire ? s_data : '0;
  assign mem_ceb   = rd_acc && rd_mode_q == BANK;
  assign mem_adb   = mem_ceb ? {rd_bank_q, rd_idx_q[IW-1:0]} : '0;
  // Pixels past a short line, and all BLANK pixels, read as black.
  assign rd_valid  = !reset && rd_valid_q;
  assign rd_data   = (!reset && rd_valid_q && rd_pix_q) ? mem_doutb : '0;
  assign underrun  = !reset && underrun_q;
  assign rd_active = !reset && rd_mode_q != IDLE;

`ifdef LINE_BUFFER_CTRL_STATS_EN
  logic [15:0] underrun_cnt_q, underrun_cnt_d;
  logic [15:0] abort_cnt_q, abort_cnt_d;
  logic        abort_ev;

  assign abort_ev = !reset && line_start && rd_mode_q == BANK;

  always_comb begin
    underrun_cnt_d = underrun_cnt_q;
    abort_cnt_d    = abort_cnt_q;
    if (underrun_d && underrun_cnt_q != 16'hffff) underrun_cnt_d = underrun_cnt_q + 16'd1;
    if (abort_ev && abort_cnt_q != 16'hffff)      abort_cnt_d    = abort_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      underrun_cnt_q <= '0;
      abort_cnt_q    <= '0;
    end else begin
      underrun_cnt_q <= underrun_cnt_d;
      abort_cnt_q    <= abort_cnt_d;
    end
  end

  assign underrun_cnt = reset ? '0 : underrun_cnt_q;
  assign abort_cnt    = reset ? '0 : abort_cnt_q;
`endif

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// tb/tb_line_buffer_ctrl.sv - self-checking bench for line_buffer_ctrl with a line-queue reference model
module tb_line_buffer_ctrl;
  localparam int LW = 480;

  logic        clk = 1'b0;
  logic        reset, s_valid, s_last, line_start, rd_en;
  logic [23:0] s_data;
  logic        s_ready, rd_valid, rd_active, underrun;
  logic [23:0] rd_data, mem_dina, mem_doutb;
  logic [9:0]  mem_ada, mem_adb;
  logic        mem_cea, mem_wrea, mem_ceb;
`ifdef LINE_BUFFER_CTRL_STATS_EN
  logic [15:0] underrun_cnt, abort_cnt;
`endif

  line_buffer_ctrl #(.LINE_W(LW), .DATA_W(24), .ADDR_W(10)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .line_start(line_start), .rd_en(rd_en), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_active(rd_active), .underrun(underrun), .mem_ada(mem_ada),
    .mem_dina(mem_dina), .mem_cea(mem_cea), .mem_wrea(mem_wrea), .mem_adb(mem_adb),
    .mem_ceb(mem_ceb), .mem_doutb(mem_doutb)
`ifdef LINE_BUFFER_CTRL_STATS_EN
    , .underrun_cnt(underrun_cnt), .abort_cnt(abort_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Dual-port RAM: 1-cycle read latency, bypass on same-address write.
  logic [23:0] ram [1024];
  always @(posedge clk) begin
    if (mem_cea && mem_wrea) ram[mem_ada] <= mem_dina;
    if (mem_ceb) mem_doutb <= (mem_cea && mem_wrea && mem_ada == mem_adb) ? mem_dina : ram[mem_adb];
  end

  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: completed lines are a queue (oldest first), pixels flattened.
  int          held_len[$];
  logic [23:0] held_pix[$];
  logic [23:0] cur[$];
  int          n_done, n_rel, mode, ridx, m_ur, m_ab;
  bit          ev_valid, ev_ur;
  logic [23:0] ev_data;

  task automatic pop_line();
    repeat (held_len[0]) void'(held_pix.pop_front());
    void'(held_len.pop_front());
    n_rel++;
  endtask

  task automatic model_step(input bit r, sv, sl, ls, re, input logic [23:0] d);
    bit wr, acc, avail;
    if (r) begin
      held_len.delete(); held_pix.delete(); cur.delete();
      n_done = 0; n_rel = 0; mode = 0; ridx = 0; m_ur = 0; m_ab = 0;
      ev_valid = 0; ev_ur = 0; ev_data = 0;
      return;
    end
    wr  = sv && held_len.size() < 2;
    acc = re && !ls && mode != 0 && ridx < LW;
    ev_valid = acc; ev_ur = 0; ev_data = 0;
    if (ls) begin
      if (mode == 1) begin pop_line(); m_ab++; end
      avail = held_len.size() > 0;
      mode = avail ? 1 : 2;
      if (!avail) begin ev_ur = 1; m_ur++; end
      ridx = 0;
    end else if (acc) begin
      if (mode == 1 && ridx < held_len[0]) ev_data = held_pix[ridx];
      ridx++;
      if (ridx == LW) begin
        if (mode == 1) pop_line();
        mode = 0;
      end
    end
    if (wr) begin
      cur.push_back(d);
      if (sl || cur.size() == LW) begin
        held_len.push_back(cur.size());
        foreach (cur[i]) held_pix.push_back(cur[i]);
        cur.delete();
        n_done++;
      end
    end
  endtask

  task automatic cycle(input bit r, sv, sl, ls, re, input logic [23:0] d);
    bit wr, acc;
    reset = r; s_valid = sv; s_last = sl; line_start = ls; rd_en = re; s_data = d;
    #4;
    wr  = !r && sv && held_len.size() < 2;
    acc = !r && re && !ls && mode == 1 && ridx < LW;
    chk("s_ready",   s_ready,   !r && held_len.size() < 2);
    chk("mem_cea",   mem_cea,   wr);
    chk("mem_wrea",  mem_wrea,  wr);
    chk("mem_ada",   mem_ada,   wr ? 10'((n_done % 2) * 512 + cur.size()) : 10'd0);
    chk("mem_dina",  mem_dina,  wr ? d : 24'd0);
    chk("mem_ceb",   mem_ceb,   acc);
    chk("mem_adb",   mem_adb,   acc ? 10'((n_rel % 2) * 512 + ridx) : 10'd0);
    chk("rd_valid",  rd_valid,  !r && ev_valid);
    chk("rd_data",   rd_data,   r ? 24'd0 : ev_data);
    chk("underrun",  underrun,  !r && ev_ur);
    chk("rd_active", rd_active, !r && mode != 0);
    model_step(r, sv, sl, ls, re, d);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string name;
    int    n;
    bit    sv;
    int    last_at;
    bit    ls;
    bit    re;
    int    base;
    bit    exp_ur;
    bit    exp_sr;
    bit    exp_act;
  } vec_t;
  vec_t vt[$];

  task automatic add(input string nm, input int n, input bit sv, input int la, input bit ls,
                     input bit re, input int base, input bit eu, input bit es, input bit ea);
    vec_t v;
    v.name = nm; v.n = n; v.sv = sv; v.last_at = la; v.ls = ls; v.re = re;
    v.base = base; v.exp_ur = eu; v.exp_sr = es; v.exp_act = ea;
    vt.push_back(v);
  endtask

  initial begin
    reset = 1; s_valid = 0; s_last = 0; line_start = 0; rd_en = 0; s_data = 0;
    //   name           n    sv last ls re base   ur sr act
    add("wr_line0",     480, 1, -1, 0, 0, 0,     0, 1, 0);
    add("ls_full",      1,   0, -1, 1, 0, 0,     0, 1, 1);
    add("rd_line0",     480, 0, -1, 0, 1, 0,     0, 1, 0);
    add("ls_empty",     1,   0, -1, 1, 0, 0,     1, 1, 1);
    add("rd_blank",     480, 0, -1, 0, 1, 0,     0, 1, 0);
    add("wr_a",         480, 1, -1, 0, 0, 1000,  0, 1, 0);
    add("wr_b",         480, 1, -1, 0, 0, 2000,  0, 0, 0);
    add("wr_blocked",   5,   1, -1, 0, 0, 3000,  0, 0, 0);
    add("ls_a",         1,   0, -1, 1, 0, 0,     0, 0, 1);
    add("rd_a",         480, 0, -1, 0, 1, 0,     0, 1, 0);
    add("wr_c10",       10,  1, 9,  0, 0, 4000,  0, 0, 0);
    add("ls_b",         1,   0, -1, 1, 0, 0,     0, 0, 1);
    add("rd_b200",      200, 0, -1, 0, 1, 0,     0, 0, 1);
    add("ls_abort",     1,   0, -1, 1, 0, 0,     0, 1, 1);
    add("rd_c",         480, 0, -1, 0, 1, 0,     0, 1, 0);
    add("wr_100",       100, 1, 99, 0, 0, 5000,  0, 1, 0);
    add("ls_100",       1,   0, -1, 1, 0, 0,     0, 1, 1);
    add("rd_100",       480, 0, -1, 0, 1, 0,     0, 1, 0);
    add("wr_481",       481, 1, -1, 0, 0, 6000,  0, 1, 0);
    add("ls_481",       1,   0, -1, 1, 0, 0,     0, 1, 1);
    add("rd_481",       480, 0, -1, 0, 1, 0,     0, 1, 0);

    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 1, 1, 24'h123);
    chk("reset_s_ready", s_ready, 1'b0);
    chk("reset_active",  rd_active, 1'b0);

    for (int p = 0; p < vt.size(); p++) begin
      for (int i = 0; i < vt[p].n; i++)
        cycle(0, vt[p].sv, vt[p].sv && i == vt[p].last_at, vt[p].ls && i == 0, vt[p].re,
              24'(vt[p].base + i));
      s_valid = 0; s_last = 0; line_start = 0; rd_en = 0;
      chk({vt[p].name, ".underrun"},  underrun,  vt[p].exp_ur);
      chk({vt[p].name, ".s_ready"},   s_ready,   vt[p].exp_sr);
      chk({vt[p].name, ".rd_active"}, rd_active, vt[p].exp_act);
    end
`ifdef LINE_BUFFER_CTRL_STATS_EN
    chk("abort_cnt_table", abort_cnt, 16'd1);
    chk("underrun_cnt_table", underrun_cnt, 16'd1);
`endif

    // Reset mid-write and mid-read.
    add("unused", 0, 0, -1, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 24'h777);
    for (int i = 0; i < 300; i++) cycle(0, 1, 0, 0, 0, 24'(7000 + i));
    cycle(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 20; i++) cycle(0, 1, 0, 0, 1, 24'(8000 + i));
    cycle(1, 1, 0, 0, 1, 24'h55);
    chk("rst_mid_rd_valid",  rd_valid,  1'b0);
    chk("rst_mid_rd_active", rd_active, 1'b0);
    chk("rst_mid_mem_cea",   mem_cea,   1'b0);
    chk("rst_mid_mem_ceb",   mem_ceb,   1'b0);
    reset = 0; s_valid = 1; s_data = 24'habcdef; rd_en = 0;
    #1;
    chk("rst_after_s_ready", s_ready, 1'b1);
    chk("rst_first_ada",     mem_ada, 10'd0);
    chk("rst_first_cea",     mem_cea, 1'b1);
    cycle(0, 1, 0, 0, 0, 24'habcdef);
    cycle(0, 0, 0, 1, 0, 0);
    chk("rst_then_underrun", underrun, 1'b1);
    for (int i = 0; i < LW; i++) cycle(0, 0, 0, 0, 1, 0);

    for (int i = 0; i < 20000; i++) begin
      bit r, sv, sl, ls, re;
      r  = $urandom_range(0, 4999) == 0;
      sv = $urandom_range(0, 9) < 6;
      sl = $urandom_range(0, 199) == 0;
      ls = $urandom_range(0, 399) == 0;
      re = !ls && $urandom_range(0, 9) < 7;
      cycle(r, sv, sl, ls, re, 24'($urandom));
    end
`ifdef LINE_BUFFER_CTRL_STATS_EN
    chk("underrun_cnt_rand", underrun_cnt, 16'(m_ur));
    chk("abort_cnt_rand",    abort_cnt,    16'(m_ab));
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/line_buffer_ctrl.md
Name: line_buffer_ctrl

Overview:
Ping-pong line-buffer controller for the 24-bit x 1024 dual-port block RAM used by the display driver. The RAM is split into two 512-entry banks. The pixel producer fills one bank through port A while the display scan reads the other through port B. Bank hand-off, underrun and short-line handling all happen here, so the display always receives exactly LINE_W pixels per line.

Parameters:
LINE_W, 480, pixels per display line; legal range 1..512
DATA_W, 24, pixel width; must match the RAM data width
ADDR_W, 10, RAM address width; bit ADDR_W-1 selects the bank

Ports:
clk  in  1  single clock for both RAM ports
reset  in  1  synchronous, active-high
s_valid  in  1  producer pixel valid
s_ready  out  1  producer may transfer this cycle
s_data  in  24  producer pixel
s_last  in  1  last pixel of the producer line
line_start  in  1  one-cycle pulse from display timing at the start of each line
rd_en  in  1  display requests the next pixel
rd_valid  out  1  rd_data valid; one cycle after an accepted rd_en
rd_data  out  24  pixel to the display
rd_active  out  1  a line is in progress (bank or blank)
underrun  out  1  one-cycle pulse when line_start finds no full bank
mem_ada  out  10  RAM port A address
mem_dina  out  24  RAM port A write data
mem_cea  out  1  RAM port A clock enable
mem_wrea  out  1  RAM port A write enable
mem_adb  out  10  RAM port B address
mem_ceb  out  1  RAM port B clock enable
mem_doutb  in  24  RAM port B read data; 1-cycle latency, bypass read mode

Behaviour:
- State: full[1:0], len0/len1 (10 bits each), wr_bank, wr_idx (9 bits), rd_bank, rd_idx (10 bits), rd_mode in {IDLE, BANK, BLANK}.
- Reset: all state cleared, rd_mode=IDLE, rd_bank=wr_bank=0. While reset is high, every output is 0 (including s_ready).
- Write side:
  - s_ready = !full[wr_bank].
  - On s_valid&&s_ready: mem_cea=mem_wrea=1, mem_ada={wr_bank,wr_idx}, mem_dina=s_data, wr_idx++.
  - The line completes on s_last, or when the LINE_W-th pixel is written (later pixels go to the next line). On completion: len[wr_bank]=wr_idx+1, full[wr_bank]=1, wr_bank toggles, wr_idx=0.
- Read side, on line_start:
  - If rd_mode=BANK, the current bank is released first: full[rd_bank]=0 and rd_bank toggles. This is an abort.
  - The new line then uses the updated rd_bank, evaluated against the registered full flags (pre-update values for this cycle).
  - full set → rd_mode=BANK. Otherwise → rd_mode=BLANK and underrun pulses.
  - rd_idx=0 in both cases.
- rd_en handling:
  - Accepted only when rd_mode!=IDLE and rd_idx<LINE_W; otherwise ignored and rd_valid stays 0.
  - BANK: mem_ceb=1, mem_adb={rd_bank,rd_idx[8:0]}.
  - Next cycle: rd_valid=1 and rd_data=mem_doutb if the registered rd_idx<len[rd_bank], else 0. Pixels past a short line read as black.
  - BLANK: rd_valid next cycle with rd_data=0.
  - rd_idx++ on each accept.
- End of line: after the LINE_W-th accept, rd_mode=IDLE. In BANK mode, full[rd_bank]=0 and rd_bank toggles.
- A completion on wr_bank and a release on rd_bank can occur in the same cycle. They never target the same bank because writes are blocked on full banks, so both updates apply.
- rd_active=1 while rd_mode!=IDLE.
- A write completing in the same cycle as line_start is not visible to that line_start.

Optional Feature:
Macro LINE_BUFFER_CTRL_STATS_EN.
- Defined: adds output underrun_cnt[15:0] and output abort_cnt[15:0]. Both are saturating counters, clear on reset, and increment on each underrun pulse and each aborted BANK line respectively.
- Undefined: neither port exists and no counter logic is built.

Test Plan:
1. Write 480 pixels with values 0..479 into bank 0, pulse line_start, then issue 480 consecutive rd_en → rd_valid trails rd_en by 1 cycle, rd_data=0..479, mem_adb=0..479, full[0] clears afterwards, and rd_bank=1.
2. line_start with no line written → underrun pulses once; 480 reads return rd_data=0; no mem_ceb activity.
3. Write two full lines (A, B) with no reads → s_ready=0 on the third line's first pixel; after line A is read out, s_ready returns to 1 and writes go to bank 0 (mem_ada[9]=0).
4. Write a 100-pixel line ending with s_last → reads 0..99 return the data, reads 100..479 return 0, len0=100.
5. line_start after 200 reads of a full line, with the next bank full → old bank freed, the new bank starts reading at index 0, and there is no underrun. With LINE_BUFFER_CTRL_STATS_EN defined, abort_cnt=1.
6. Assert reset mid-write and mid-read → the next cycle shows all outputs at 0, s_ready=1 after reset deasserts, the first write goes to address 0, and a subsequent line_start flags underrun.
